// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one request at a time to the I-cache and buffers returns for decode.
// Optional JAL target prediction is compiled in with IF_JAL_PREDICT_EN.
module instr_fetch #(
  parameter int unsigned          ADDR_SIZE  = 32,
  parameter int unsigned          INST_SIZE  = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_areset,
  output logic                 o_req,
  output logic [ADDR_SIZE-1:0] o_addr,
  input  logic                 i_instr_valid,
  input  logic [INST_SIZE-1:0] i_instruction,
  input  logic                 i_redirect,
  input  logic [ADDR_SIZE-1:0] i_redirect_pc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [INST_SIZE-1:0] o_instr,
  output logic [ADDR_SIZE-1:0] o_pc,
  output logic                 o_pred_taken
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_STALL   = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

  logic [INST_SIZE-1:0] instr_mem_q [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] pc_mem_q    [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [CNT_W-1:0]     count_if_push;
  logic [ADDR_SIZE-1:0] next_pc;
  logic [ADDR_SIZE-1:0] redirect_pc;

  assign redirect_pc   = i_redirect_pc & ~ADDR_SIZE'(3);
  assign count_if_push = count_q + CNT_W'(1) - CNT_W'(pop);

`ifdef IF_JAL_PREDICT_EN
  logic        is_jal;
  logic [20:0] jal_imm;
  logic        pred_mem_q [FIFO_DEPTH];

  // J-type immediate: imm[20|10:1|11|19:12] sits in instruction bits [31:12]
  assign is_jal  = (i_instruction[6:0] == 7'b1101111);
  assign jal_imm = {i_instruction[31], i_instruction[19:12], i_instruction[20],
                    i_instruction[30:21], 1'b0};
  assign next_pc = is_jal ? req_addr_q + ADDR_SIZE'($signed(jal_imm))
                          : req_addr_q + ADDR_SIZE'(4);

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) pred_mem_q[i] <= 1'b0;
    end else if (push) begin
      pred_mem_q[wr_ptr_q] <= is_jal;
    end
  end

  assign o_pred_taken = pred_mem_q[rd_ptr_q];
`else
  assign next_pc      = req_addr_q + ADDR_SIZE'(4);
  assign o_pred_taken = 1'b0;
`endif

  // Next-state: redirect always wins; a word returning for a superseded request is never pushed
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = valid_q & i_ready;

    case (state_q)
      S_FETCH: begin
        if (i_redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = (req_q && !i_instr_valid) ? S_DISCARD : S_FETCH;
        end else if (req_q && i_instr_valid) begin
          push    = 1'b1;
          pc_d    = next_pc;
          state_d = (count_if_push < CNT_W'(FIFO_DEPTH)) ? S_FETCH : S_STALL;
        end
      end
      S_STALL: begin
        if (i_redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (pop) begin
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (i_redirect) pc_d = redirect_pc;
        if (i_instr_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A fresh request samples the PC whenever the previous one finished or none was active
    if (state_d == S_FETCH && (!req_q || i_instr_valid)) req_addr_d = pc_d;
    req_d = (state_d != S_STALL);

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= i_instruction;
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  assign o_req   = req_q;
  assign o_addr  = req_addr_q;
  assign o_valid = valid_q;
  assign o_instr = instr_mem_q[rd_ptr_q];
  assign o_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage sitting directly upstream of the instruction cache controller. Owns the program counter, issues one-at-a-time requests to the cache using its level request/address protocol, and buffers returned instructions in a small FIFO with a valid/ready handshake toward decode. Handles execute-stage redirects, including redirects that arrive while a cache request is already in flight.

## Interface
- ADDR_SIZE, 32, PC/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- i_clk  in  1  system clock.
- i_areset  in  1  asynchronous, active-high reset.
- o_req  out  1  request to cache; level, held until i_instr_valid.
- o_addr  out  ADDR_SIZE  fetch address to cache; stable while o_req is high.
- i_instr_valid  in  1  single-cycle pulse: cache returns the instruction for o_addr.
- i_instruction  in  INST_SIZE  instruction word, qualified by i_instr_valid.
- i_redirect  in  1  single-cycle pulse from execute: flush and restart.
- i_redirect_pc  in  ADDR_SIZE  new PC; bits [1:0] are ignored and treated as 0.
- o_valid  out  1  FIFO head valid to decode.
- i_ready  in  1  decode accepts the head.
- o_instr  out  INST_SIZE  head instruction.
- o_pc  out  ADDR_SIZE  head PC.
- o_pred_taken  out  1  head was predicted taken; constant 0 without the macro.

## Operation
- Registers:
  - pc: next address to fetch.
  - req_addr: drives o_addr.
  - FIFO: entries of {instr, pc, pred}.
  - count: 0..FIFO_DEPTH.
- At most one request is outstanding. A request starts only in FETCH, with count < FIFO_DEPTH. Starting a request loads req_addr ← pc.
- State FETCH:
  - o_req = 1.
  - On i_instr_valid: push {i_instruction, req_addr, pred}; pc ← req_addr + 4, or the JAL target when the macro is enabled.
  - Then stay in FETCH if count after push/pop < FIFO_DEPTH; otherwise go to STALL.
- State STALL:
  - o_req = 0.
  - Return to FETCH when a pop makes count < FIFO_DEPTH.
- State DISCARD:
  - Entered on a redirect while o_req is high without i_instr_valid in the same cycle.
  - o_req stays high with the old o_addr, because the cache reads the address combinationally during its transaction.
  - When i_instr_valid arrives, the word is dropped (no push) and the state goes to FETCH.
- Redirect, in any state:
  - FIFO flushed (count ← 0).
  - pc ← {i_redirect_pc[ADDR_SIZE-1:2], 2'b00}.
  - Redirect wins over a same-cycle push and a same-cycle pop.
  - Redirect in STALL or FETCH with i_instr_valid in the same cycle: go to FETCH and drop the returned word.
  - Redirect in DISCARD: only pc is updated.
- FIFO:
  - Push and pop in the same cycle with count == FIFO_DEPTH is legal, and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop only when o_valid && i_ready.
- PC arithmetic wraps modulo 2^ADDR_SIZE.

## Timing
- Reset values:
  - o_req = 0, o_addr = RESET_PC, o_valid = 0, o_instr = 0, o_pc = 0, o_pred_taken = 0.
  - count = 0, state FETCH, pc = RESET_PC.
- The first o_req goes high in the first cycle after i_areset deasserts.
- After an i_instr_valid pulse in FETCH with space remaining, o_req stays high and o_addr takes the new pc in the next cycle. The cache sees this as a fresh request.
- Push to o_valid latency: 1 cycle. o_valid/o_instr come from registers.
- Redirect to o_req at the new PC:
  - 1 cycle from STALL or FETCH with no request in flight.
  - Otherwise 1 cycle after the discarded i_instr_valid.
- Reset mid-request: all state is cleared immediately; the in-flight word is never pushed.

## Configuration
- IF_JAL_PREDICT_EN defined:
  - A pushed instruction with opcode [6:0] == 7'b1101111 (JAL) sets pred = 1.
  - pc ← req_addr + sign-extended J-immediate, as imm[20|10:1|11|19:12] from bits [31:12], LSB 0.
- IF_JAL_PREDICT_EN undefined:
  - pred is always 0 and pc always advances by 4.
  - o_pred_taken is tied 0.

## Test plan
- Reset release, cache answers every request 2 cycles after o_req rises, i_ready = 1 → o_addr sequence 0x0, 0x4, 0x8; o_pc matches; o_valid 1 cycle after each pulse.
- i_ready = 0 with FIFO_DEPTH = 2 → after two returns o_req drops, state STALL; one pop → o_req reasserts at 0x8 on the next cycle.
- Redirect to 0x103 while a request at 0x10 is pending, miss returning 5 cycles later → o_addr held at 0x10 until the return, word discarded, next o_addr = 0x100, FIFO empty in between.
- Redirect to 0x200 in the same cycle as i_instr_valid and a pop → no push, count = 0, next o_addr = 0x200.
- With IF_JAL_PREDICT_EN: instruction 32'h0080006F (jal x0, +8) at 0x20 → o_pred_taken = 1 for that entry, next o_addr = 0x28. Without the macro → next o_addr = 0x24 and o_pred_taken = 0.
- i_areset pulsed while o_req is high mid-miss → o_req = 0 and o_valid = 0 immediately; after release, o_addr = RESET_PC.
